// File: rtl/rgb_chroma_pkg.sv
// Shared definitions for the RGB colour sequencer: palette, colour index type and FSM encoding.
// Palette entries are stored as abstract levels so any duty width scales cleanly.
package rgb_chroma_pkg;

  localparam int NUM_COLORS = 8;

  typedef logic [2:0] color_idx_t;

  typedef enum logic {
    HOLD = 1'b0,
    FADE = 1'b1
  } seq_state_e;

  typedef enum logic [1:0] {
    LVL_OFF  = 2'd0,
    LVL_HALF = 2'd1,
    LVL_FULL = 2'd2
  } level_e;

  typedef struct packed {
    level_e r;
    level_e g;
    level_e b;
  } color_t;

  function automatic color_t palette_color(color_idx_t idx);
    case (idx)
      3'd0:    return '{LVL_FULL, LVL_OFF,  LVL_OFF };  // red
      3'd1:    return '{LVL_FULL, LVL_FULL, LVL_OFF };  // yellow
      3'd2:    return '{LVL_OFF,  LVL_FULL, LVL_OFF };  // green
      3'd3:    return '{LVL_OFF,  LVL_FULL, LVL_FULL};  // cyan
      3'd4:    return '{LVL_OFF,  LVL_OFF,  LVL_FULL};  // blue
      3'd5:    return '{LVL_FULL, LVL_OFF,  LVL_FULL};  // magenta
      3'd6:    return '{LVL_FULL, LVL_FULL, LVL_FULL};  // white
      default: return '{LVL_FULL, LVL_HALF, LVL_OFF };  // orange
    endcase
  endfunction

  // Channel 0 = red, 1 = green, 2 = blue.
  function automatic level_e palette_level(color_idx_t idx, int ch);
    color_t c;
    c = palette_color(idx);
    case (ch)
      0:       return c.r;
      1:       return c.g;
      default: return c.b;
    endcase
  endfunction

  // Full scale is 2**w-1; half scale is the MSB alone (0x80 for w=8). Valid for 1 <= w <= 32.
  function automatic logic [31:0] level_value(level_e lvl, int w);
    case (lvl)
      LVL_FULL: return 32'hFFFF_FFFF >> (32 - w);
      LVL_HALF: return 32'd1 << (w - 1);
      default:  return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/rgb_step_tick.sv
// Free-running prescaler: one-cycle tick every STEP_DIV cycles; clr restarts the period so
// the first tick after a clear lands STEP_DIV cycles later.
module rgb_step_tick #(
  parameter int STEP_DIV = 195_312
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr || tick) cnt_q <= '0;
    else                      cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/rgb_color_sequencer.sv
// Steps R/G/B duty words through the palette with 1-LSB-per-tick linear crossfades,
// advancing on btn_next or, in auto mode, after HOLD_CYCLES of settled colour.
module rgb_color_sequencer
  import rgb_chroma_pkg::*;
#(
  parameter int DUTY_W      = 8,
  parameter int STEP_DIV    = 195_312,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              btn_mode,
  output logic [DUTY_W-1:0] R_duty,
  output logic [DUTY_W-1:0] G_duty,
  output logic [DUTY_W-1:0] B_duty,
  output logic [2:0]        color_idx,
  output logic              auto_mode,
  output logic              busy
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef logic [DUTY_W-1:0] duty_t;

  seq_state_e        state_q, state_d;
  color_idx_t        color_q, color_d;
  color_idx_t        target_q, target_d;
  logic              pending_q, pending_d;
  logic              auto_q, auto_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  duty_t             duty_q [3];
  duty_t             duty_d [3];
  duty_t             goal   [3];
  logic              step_tick, step_clr, advance, at_goal;

  function automatic duty_t chan_value(color_idx_t idx, int ch);
    return DUTY_W'(level_value(palette_level(idx, ch), DUTY_W));
  endfunction

  function automatic duty_t step_toward(duty_t cur, duty_t tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  rgb_step_tick #(.STEP_DIV(STEP_DIV)) u_step_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (step_clr),
    .tick  (step_tick)
  );

  always_comb begin
    for (int ch = 0; ch < 3; ch++) goal[ch] = chan_value(target_q, ch);
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
    target_d  = target_q;
    pending_d = pending_q;
    auto_d    = auto_q;
    hold_d    = hold_q;
    for (int ch = 0; ch < 3; ch++) duty_d[ch] = duty_q[ch];
    step_clr  = 1'b0;
    advance   = 1'b0;
    at_goal   = 1'b1;

    case (state_q)
      HOLD: begin
        if (auto_q) begin
          if (hold_q == HOLD_LAST) begin
            advance = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          hold_d = '0;
        end
        if (btn_next) advance = 1'b1;
        if (advance) begin
          target_d = color_q + 3'd1;
          state_d  = FADE;
          step_clr = 1'b1;
          hold_d   = '0;
        end
      end
      FADE: begin
        hold_d = '0;
        if (btn_next) pending_d = 1'b1;
        if (step_tick) begin
          for (int ch = 0; ch < 3; ch++) begin
            duty_d[ch] = step_toward(duty_q[ch], goal[ch]);
            if (duty_d[ch] != goal[ch]) at_goal = 1'b0;
          end
          // A queued press chains straight into the next fade without a settled HOLD cycle.
          if (at_goal) begin
            color_d = target_q;
            if (pending_d) begin
              pending_d = 1'b0;
              target_d  = target_q + 3'd1;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      default: state_d = HOLD;
    endcase

    if (btn_mode) begin
      auto_d = ~auto_q;
      hold_d = '0;
    end
  end

  // NOTE: the duty registers are only three words, so they are reset like any other state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HOLD;
      color_q   <= '0;
      target_q  <= '0;
      pending_q <= 1'b0;
      auto_q    <= 1'b0;
      hold_q    <= '0;
      for (int ch = 0; ch < 3; ch++) duty_q[ch] <= chan_value(3'd0, ch);
    end else begin
      state_q   <= state_d;
      color_q   <= color_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      auto_q    <= auto_d;
      hold_q    <= hold_d;
      for (int ch = 0; ch < 3; ch++) duty_q[ch] <= duty_d[ch];
    end
  end

  assign R_duty    = duty_q[0];
  assign G_duty    = duty_q[1];
  assign B_duty    = duty_q[2];
  assign color_idx = color_q;
  assign auto_mode = auto_q;
  assign busy      = (state_q == FADE);

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Self-checking bench: directed scenarios plus random button traffic, every cycle compared
// against a behavioural model built from the palette table and fade rules.
module tb_rgb_color_sequencer;

  localparam int DUTY_W      = 8;
  localparam int STEP_DIV    = 4;
  localparam int HOLD_CYCLES = 20;

  localparam logic [23:0] PAL [8] = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
                                      24'h0000FF, 24'hFF00FF, 24'hFFFFFF, 24'hFF8000};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              btn_next = 1'b0;
  logic              btn_mode = 1'b0;
  logic [DUTY_W-1:0] R_duty, G_duty, B_duty;
  logic [2:0]        color_idx;
  logic              auto_mode, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: channel levels, settled/target colour, fade/pending/auto flags,
  // cycles spent in the current hold and cycles since the last fade step.
  int m_ch [3];
  int m_idx, m_tgt, m_hold, m_phase;
  bit m_fade, m_pend, m_auto;

  rgb_color_sequencer #(
    .DUTY_W      (DUTY_W),
    .STEP_DIV    (STEP_DIV),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_next  (btn_next),
    .btn_mode  (btn_mode),
    .R_duty    (R_duty),
    .G_duty    (G_duty),
    .B_duty    (B_duty),
    .color_idx (color_idx),
    .auto_mode (auto_mode),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pal_ch(int idx, int ch);
    logic [23:0] c;
    c = PAL[idx];
    return int'((c >> (8 * (2 - ch))) & 24'hFF);
  endfunction

  task automatic model_step(input bit n, input bit m, input bit r);
    bit fire, done;
    int g;
    if (r) begin
      for (int c = 0; c < 3; c++) m_ch[c] = pal_ch(0, c);
      m_idx = 0; m_tgt = 0; m_hold = 0; m_phase = 0;
      m_fade = 0; m_pend = 0; m_auto = 0;
      return;
    end
    if (!m_fade) begin
      fire   = m_auto && (m_hold == HOLD_CYCLES - 1);
      m_hold = (m_auto && !fire) ? m_hold + 1 : 0;
      if (n || fire) begin
        m_fade  = 1;
        m_tgt   = (m_idx + 1) % 8;
        m_phase = 0;
        m_hold  = 0;
      end
    end else begin
      if (n) m_pend = 1;
      if (m_phase == STEP_DIV - 1) begin
        m_phase = 0;
        done = 1;
        for (int c = 0; c < 3; c++) begin
          g = pal_ch(m_tgt, c);
          if (m_ch[c] < g) m_ch[c]++;
          else if (m_ch[c] > g) m_ch[c]--;
          if (m_ch[c] != g) done = 0;
        end
        if (done) begin
          m_idx = m_tgt;
          if (m_pend) begin
            m_pend = 0;
            m_tgt  = (m_tgt + 1) % 8;
          end else begin
            m_fade = 0;
          end
        end
      end else begin
        m_phase++;
      end
    end
    if (m) begin
      m_auto = !m_auto;
      m_hold = 0;
    end
  endtask

  function automatic logic [28:0] model_snapshot();
    return {8'(m_ch[0]), 8'(m_ch[1]), 8'(m_ch[2]), 3'(m_idx), m_auto, m_fade};
  endfunction

  // One clock: apply inputs, advance the model, then compare all outputs 1 time unit after the edge.
  task automatic cycle(input bit n, input bit m, input bit r);
    btn_next = n;
    btn_mode = m;
    reset    = r;
    @(posedge clk);
    #1;
    model_step(n, m, r);
    btn_next = 1'b0;
    btn_mode = 1'b0;
    reset    = 1'b0;
    check("outputs_vs_model", {R_duty, G_duty, B_duty, color_idx, auto_mode, busy}, model_snapshot());
  endtask

  task automatic run_until_idle(input int bound, output int busy_cycles);
    busy_cycles = 0;
    while (busy && busy_cycles < bound) begin
      cycle(1'b0, 1'b0, 1'b0);
      if (busy) busy_cycles++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int n, total, idle;

    // 1. reset
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    check("reset_rgb", {R_duty, G_duty, B_duty}, 24'hFF0000);
    check("reset_idx", color_idx, 3'd0);
    check("reset_busy_auto", {busy, auto_mode}, 2'b00);

    // 2. single advance red -> yellow, 255 ticks of 4 cycles
    cycle(1'b1, 1'b0, 1'b0);
    check("t2_busy_next_cycle", busy, 1'b1);
    run_until_idle(3000, n);
    total = 1 + n;
    check("t2_fade_cycles", total, 1020);
    check("t2_rgb", {R_duty, G_duty, B_duty}, 24'hFFFF00);
    check("t2_idx", color_idx, 3'd1);

    // 3. two presses during fade 0->1 queue exactly one more fade
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    total = 1;
    for (int i = 1; i <= 40; i++) begin
      cycle(i == 10 || i == 30, 1'b0, 1'b0);
      if (busy) total++;
    end
    run_until_idle(5000, n);
    total += n;
    check("t3_chained_busy_cycles", total, 2040);
    check("t3_rgb", {R_duty, G_duty, B_duty}, 24'h00FF00);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 1'b0);
    check("t3_idx_settled", color_idx, 3'd2);

    // 4. walk to orange, then wrap 7 -> 0 (G 80 -> 00 in 128 ticks)
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, 1'b0);
      run_until_idle(3000, n);
    end
    check("t4_at_orange", {R_duty, G_duty, B_duty, color_idx}, {24'hFF8000, 3'd7});
    cycle(1'b1, 1'b0, 1'b0);
    run_until_idle(3000, n);
    total = 1 + n;
    check("t4_wrap_cycles", total, 512);
    check("t4_wrap_rgb", {R_duty, G_duty, B_duty}, 24'hFF0000);
    check("t4_wrap_idx", color_idx, 3'd0);

    // 5. auto mode hold length, then reset mid-fade
    cycle(1'b0, 1'b1, 1'b0);
    check("t5_auto_on", auto_mode, 1'b1);
    idle = 0;
    for (int i = 0; i < 100 && !busy; i++) begin
      idle++;
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("t5_hold_len", idle, HOLD_CYCLES);
    check("t5_auto_fade_started", busy, 1'b1);
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("t5_reset_mid_fade", {R_duty, G_duty, B_duty, color_idx, auto_mode, busy},
          {24'hFF0000, 3'd0, 1'b0, 1'b0});

    // 6. simultaneous next+mode, then mode toggled off during the fade
    cycle(1'b1, 1'b1, 1'b0);
    check("t6_both_effect", {busy, auto_mode}, 2'b11);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check("t6_auto_off", auto_mode, 1'b0);
    run_until_idle(3000, n);
    check("t6_fade_done", {R_duty, G_duty, B_duty, color_idx, auto_mode}, {24'hFFFF00, 3'd1, 1'b0});

    // 7. random traffic against the model
    for (int i = 0; i < 6000; i++)
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 2499) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
